// File: rtl/lector_display.sv
// lector_display: watches a multiplexed, active-low 7-segment bus and rebuilds
// the four displayed BCD digits. A {anodos, segments} pattern must be seen on
// ESTABLE consecutive strobed samples before it is treated as a real capture.
module lector_display #(
   parameter int ESTABLE = 3
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        muestra,
   input  logic [7:0]  controles_display,
   input  logic [3:0]  anodos,
   output logic [15:0] digitos,
   output logic [3:0]  valido,
   output logic        error,
   output logic        trama_lista,
   output logic [7:0]  conteo_errores
);

   localparam logic [3:0] EST = 4'(ESTABLE);

   // Segment code to {legal, value}; anything outside the ten digit glyphs
   // (including a lit decimal point) is reported as illegal.
   function automatic logic [4:0] decodificar(input logic [7:0] seg);
      logic [4:0] r;
      case (seg)
         8'h03:   r = {1'b1, 4'd0};
         8'h9F:   r = {1'b1, 4'd1};
         8'h25:   r = {1'b1, 4'd2};
         8'h0D:   r = {1'b1, 4'd3};
         8'h99:   r = {1'b1, 4'd4};
         8'h49:   r = {1'b1, 4'd5};
         8'h41:   r = {1'b1, 4'd6};
         8'h1F:   r = {1'b1, 4'd7};
         8'h01:   r = {1'b1, 4'd8};
         8'h09:   r = {1'b1, 4'd9};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   // Error counter increment that sticks at full scale.
   function automatic logic [7:0] sumar_sat(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [11:0] entrada;
   logic [11:0] retenido_p0;
   logic [3:0]  cnt_p0;
   logic [3:0]  cnt_sig;
   logic        iguales;
   logic        evento;
   logic        vld_p1;
   logic [11:0] dato_p1;
   logic [3:0]  mascara_p2;

   logic [4:0]  dec;
   logic [1:0]  idx;
   logic        sel_ok;
   logic [3:0]  bit_sel;
   logic [3:0]  mascara_nueva;
   logic [15:0] digitos_sig;

   assign entrada = {anodos, controles_display};

   // ---- stage 0: stability counting and capture-event detection ----

   // Next repeat count and whether this strobe completes a stable period.
   // The "value changed" term lets ESTABLE=1 fire on every new pattern even
   // though the count was already sitting at 1 for the previous one.
   always_comb begin
      iguales = (entrada == retenido_p0);
      cnt_sig = cnt_p0;
      if (muestra) begin
         if (iguales) begin
            cnt_sig = (cnt_p0 >= EST) ? EST : cnt_p0 + 4'd1;
         end else begin
            cnt_sig = 4'd1;
         end
      end
      evento = muestra && (cnt_sig == EST) && (!iguales || (cnt_p0 != EST));
   end

   // Held sample and its repeat count only move on strobed edges.
   always_ff @(posedge CLK) begin
      if (reset) begin
         retenido_p0 <= 12'hFFF;
         cnt_p0      <= 4'd0;
      end else if (muestra) begin
         retenido_p0 <= entrada;
         cnt_p0      <= cnt_sig;
      end
   end

   // ---- stage 1: registered capture event ----

   // Event flag; reset drops any capture that is still in flight.
   always_ff @(posedge CLK) begin
      if (reset) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= evento;
      end
   end

   // Pattern travelling with the event flag; only meaningful when vld_p1=1.
   always_ff @(posedge CLK) begin
      dato_p1 <= entrada;
   end

   // ---- stage 2: decode and output update ----

   // Digit selection (exactly one anode low) and decoded update values.
   always_comb begin
      dec    = decodificar(dato_p1[7:0]);
      sel_ok = 1'b1;
      idx    = 2'd0;
      case (dato_p1[11:8])
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: sel_ok = 1'b0;
      endcase
      bit_sel       = 4'b0001 << idx;
      mascara_nueva = mascara_p2 | bit_sel;
      digitos_sig   = digitos;
      digitos_sig[{idx, 2'b00} +: 4] = dec[3:0];
   end

   // Output registers; error and trama_lista are single-cycle pulses.
   always_ff @(posedge CLK) begin
      if (reset) begin
         digitos        <= 16'h0000;
         valido         <= 4'b0000;
         error          <= 1'b0;
         trama_lista    <= 1'b0;
         conteo_errores <= 8'h00;
         mascara_p2     <= 4'b0000;
      end else begin
         error       <= 1'b0;
         trama_lista <= 1'b0;
         if (vld_p1 && sel_ok) begin
            if (dec[4]) begin
               digitos     <= digitos_sig;
               valido[idx] <= 1'b1;
               if (mascara_nueva == 4'b1111) begin
                  trama_lista <= 1'b1;
                  mascara_p2  <= 4'b0000;
               end else begin
                  mascara_p2 <= mascara_nueva;
               end
            end else begin
               valido[idx]     <= 1'b0;
               mascara_p2[idx] <= 1'b0;
               error           <= 1'b1;
               conteo_errores  <= sumar_sat(conteo_errores);
            end
         end
      end
   end

endmodule

// File: tb/tb_lector_display.sv
// Bench for lector_display: a cycle model predicts the outputs after every
// edge, the prediction is queued, and the DUT is compared against it 1 ns
// after the edge. A few directed checks against hand-derived constants too.
module tb_lector_display;

   localparam int EST = 3;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        muestra = 1'b0;
   logic [7:0]  controles_display = 8'hFF;
   logic [3:0]  anodos = 4'hF;
   logic [15:0] digitos;
   logic [3:0]  valido;
   logic        error;
   logic        trama_lista;
   logic [7:0]  conteo_errores;

   lector_display #(.ESTABLE(EST)) dut (
      .CLK               (CLK),
      .reset             (reset),
      .muestra           (muestra),
      .controles_display (controles_display),
      .anodos            (anodos),
      .digitos           (digitos),
      .valido            (valido),
      .error             (error),
      .trama_lista       (trama_lista),
      .conteo_errores    (conteo_errores)
   );

   always #5 CLK = ~CLK;

   int vectores = 0;
   int fallos = 0;
   int tramas_vistas = 0;
   int errores_vistos = 0;
   logic [29:0] esperado_q[$];

   // Reference model state
   logic [11:0] m_held;
   int          m_cnt;
   logic        m_pend;
   logic [11:0] m_dato;
   logic [3:0]  m_dig [4];
   logic [3:0]  m_val;
   logic [3:0]  m_mask;
   logic        m_err;
   logic        m_trama;
   int          m_errc;
   logic [7:0]  tabla [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectores++;
      if (obs !== exp) begin
         fallos++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic aplicar_captura(input logic [11:0] d);
      int ceros = 0;
      int pos = 0;
      int valor = -1;
      for (int i = 0; i < 4; i++) begin
         if (!d[8+i]) begin
            ceros++;
            pos = i;
         end
      end
      if (ceros != 1) return;
      for (int v = 0; v < 10; v++) begin
         if (tabla[v] == d[7:0]) valor = v;
      end
      if (valor >= 0) begin
         m_dig[pos]  = 4'(valor);
         m_val[pos]  = 1'b1;
         m_mask[pos] = 1'b1;
         if (m_mask == 4'hF) begin
            m_trama = 1'b1;
            m_mask  = 4'h0;
         end
      end else begin
         m_val[pos]  = 1'b0;
         m_mask[pos] = 1'b0;
         m_err       = 1'b1;
         if (m_errc < 255) m_errc++;
      end
   endtask

   task automatic modelo(input logic r, input logic mu, input logic [11:0] ent);
      if (r) begin
         for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
         m_val = 4'h0; m_mask = 4'h0; m_err = 1'b0; m_trama = 1'b0; m_errc = 0;
         m_held = 12'hFFF; m_cnt = 0; m_pend = 1'b0;
         return;
      end
      m_err   = 1'b0;
      m_trama = 1'b0;
      if (m_pend) aplicar_captura(m_dato);
      m_pend = 1'b0;
      if (mu) begin
         m_dato = ent;
         if (ent == m_held) begin
            if (m_cnt < EST) begin
               m_cnt++;
               m_pend = (m_cnt == EST);
            end
         end else begin
            m_held = ent;
            m_cnt  = 1;
            m_pend = (EST == 1);
         end
      end
   endtask

   function automatic logic [29:0] esperado();
      return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_val, m_err, m_trama, 8'(m_errc)};
   endfunction

   // Drive n edges with the given inputs, predicting and checking each one.
   task automatic ciclo(input logic r, input logic mu, input logic [3:0] an,
                        input logic [7:0] cd, input int n = 1);
      logic [29:0] exp;
      for (int k = 0; k < n; k++) begin
         reset = r; muestra = mu; anodos = an; controles_display = cd;
         @(posedge CLK);
         modelo(r, mu, {an, cd});
         esperado_q.push_back(esperado());
         #1;
         exp = esperado_q.pop_front();
         comprobar("ciclo", {2'b00, digitos, valido, error, trama_lista, conteo_errores},
                   {2'b00, exp});
         if (trama_lista === 1'b1) tramas_vistas++;
         if (error === 1'b1) errores_vistos++;
      end
   endtask

   initial begin
      // Reset for two cycles, then idle
      ciclo(1, 0, 4'hF, 8'hFF, 2);
      comprobar("rst_dig", 32'(digitos), 32'h0);
      comprobar("rst_cnt", 32'(conteo_errores), 32'h0);
      ciclo(0, 0, 4'hF, 8'hFF, 3);
      comprobar("idle_val", 32'(valido), 32'h0);

      // Single digit 1 on position 0, then redundant samples
      ciclo(0, 1, 4'b1110, 8'h9F, 3);
      ciclo(0, 0, 4'b1110, 8'h9F, 1);
      comprobar("d0_dig", 32'(digitos[3:0]), 32'h1);
      comprobar("d0_val", 32'(valido), 32'b0001);
      ciclo(0, 1, 4'b1110, 8'h9F, 4);
      ciclo(0, 0, 4'b1110, 8'h9F, 2);

      // Complete frame 4321
      ciclo(0, 1, 4'b1101, 8'h25, 3);
      ciclo(0, 1, 4'b1011, 8'h0D, 3);
      ciclo(0, 1, 4'b0111, 8'h99, 3);
      ciclo(0, 0, 4'b0111, 8'h99, 1);
      comprobar("frame_pulse", 32'(trama_lista), 32'h1);
      ciclo(0, 0, 4'b0111, 8'h99, 2);
      comprobar("frame_dig", 32'(digitos), 32'h4321);
      comprobar("frame_val", 32'(valido), 32'hF);
      comprobar("frame_count", 32'(tramas_vistas), 32'd1);

      // Recapture after the frame must not pulse (mask was cleared)
      ciclo(0, 1, 4'b1101, 8'h41, 3);
      ciclo(0, 0, 4'b1101, 8'h41, 2);
      comprobar("recap_nopulse", 32'(tramas_vistas), 32'd1);

      // Illegal code on digit 2
      ciclo(0, 1, 4'b1011, 8'hFF, 3);
      ciclo(0, 0, 4'b1011, 8'hFF, 1);
      comprobar("ill_err", 32'(error), 32'h1);
      comprobar("ill_val", 32'(valido), 32'b1011);
      comprobar("ill_dig2", 32'(digitos[11:8]), 32'h3);
      comprobar("ill_cnt", 32'(conteo_errores), 32'd1);
      ciclo(0, 0, 4'b1011, 8'hFF, 1);
      comprobar("ill_err_off", 32'(error), 32'h0);

      // Code changing mid-period, two anodes low, muestra gaps
      ciclo(0, 1, 4'b1100, 8'h03, 2);
      ciclo(0, 1, 4'b1100, 8'h0D, 1);
      ciclo(0, 0, 4'b1100, 8'h0D, 1);
      ciclo(0, 1, 4'b1100, 8'h0D, 1);
      ciclo(0, 0, 4'b1100, 8'h0D, 1);
      ciclo(0, 1, 4'b1100, 8'h0D, 1);
      ciclo(0, 0, 4'b1100, 8'h0D, 2);
      comprobar("multi_an_cnt", 32'(conteo_errores), 32'd1);
      ciclo(0, 1, 4'b1110, 8'h09, 1);
      ciclo(0, 0, 4'b1110, 8'hFF, 1);
      ciclo(0, 1, 4'b1110, 8'h09, 1);
      ciclo(0, 0, 4'b1101, 8'h25, 1);
      ciclo(0, 1, 4'b1110, 8'h09, 1);
      ciclo(0, 0, 4'b1110, 8'h09, 1);
      comprobar("gap_dig0", 32'(digitos[3:0]), 32'h9);

      // Saturating error counter
      for (int k = 0; k < 260; k++) begin
         ciclo(0, 1, 4'b0111, (k % 2 == 1) ? 8'hFF : 8'hFE, 3);
      end
      ciclo(0, 0, 4'b0111, 8'hFF, 2);
      comprobar("sat_cnt", 32'(conteo_errores), 32'd255);
      comprobar("sat_pulses", 32'(errores_vistos), 32'd261);

      // Capture in flight discarded by reset
      ciclo(0, 1, 4'b1101, 8'h41, 3);
      ciclo(1, 0, 4'b1101, 8'h41, 1);
      ciclo(0, 0, 4'b1101, 8'h41, 2);
      comprobar("flight_dig", 32'(digitos), 32'h0);
      comprobar("flight_val", 32'(valido), 32'h0);

      // Reset between 2nd and 3rd sample, then full period needed
      ciclo(0, 1, 4'b1110, 8'h49, 2);
      ciclo(1, 1, 4'b1110, 8'h49, 1);
      ciclo(0, 1, 4'b1110, 8'h49, 1);
      ciclo(0, 0, 4'b1110, 8'h49, 2);
      comprobar("mid_rst_val", 32'(valido), 32'h0);
      ciclo(0, 1, 4'b1110, 8'h49, 2);
      ciclo(0, 0, 4'b1110, 8'h49, 1);
      comprobar("post_rst_dig", 32'(digitos[3:0]), 32'h5);
      comprobar("post_rst_val", 32'(valido), 32'b0001);
      ciclo(0, 0, 4'b1110, 8'h49, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
      $finish;
   end

endmodule
